// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared pipeline constants, control group type and decode helpers
package id_ex_stage_pkg;

    // Opcodes the ID/EX stage needs to recognise
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // RegDst encodings
    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_RA   = 2'd2;
    localparam logic [1:0] REGDST_RSVD = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Control group carried from ID to EX
    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memRead;
        logic aluSrc;
        logic valid;
    } ctrl_t;

    // A bubble is an invalid instruction with every side effect disabled
    localparam ctrl_t CTRL_BUBBLE = 5'b0;

    function automatic logic usesRs(input logic [5:0] op);
        return !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
    endfunction

    function automatic logic usesRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SW) || (op == OP_SB);
    endfunction

    // Reserved RegDst encoding falls back to rt
    function automatic logic [4:0] resolveDest(input logic [1:0] regDst,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        logic [4:0] dest;
        case (regDst)
            REGDST_RD: dest = rd;
            REGDST_RA: dest = REG_RA;
            default:   dest = rt;
        endcase
        return dest;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detection
//
// Ports:
//   memReadEx, validEx, regWrAddrEx : load currently in EX and its destination
//   opCodeId, rsAddrId, rtAddrId    : instruction in ID
//   rsUsed, rtUsed                  : which source registers the ID opcode reads
//   hazard                          : ID consumes the EX load result this cycle
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic       memReadEx,
    input  logic       validEx,
    input  logic [4:0] regWrAddrEx,
    input  logic [5:0] opCodeId,
    input  logic [4:0] rsAddrId,
    input  logic [4:0] rtAddrId,
    output logic       rsUsed,
    output logic       rtUsed,
    output logic       hazard
);

    logic loadInEx;

    always_comb begin
        rsUsed   = usesRs(opCodeId);
        rtUsed   = usesRt(opCodeId);
        // $0 is never really written, so a load to it cannot create a dependency
        loadInEx = memReadEx && validEx && (regWrAddrEx != REG_ZERO);
        hazard   = loadInEx &&
                   ((rsUsed && (regWrAddrEx == rsAddrId)) ||
                    (rtUsed && (regWrAddrEx == rtAddrId)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush bubble
//
// Ports:
//   clk, reset (async active-low)
//   Flush                     : squash the ID instruction (taken branch/jump)
//   *_ID                      : decoded opcode, register fields, control and data from ID
//   Stall_ID                  : combinational; hold PC and IF/ID
//   *_EX                      : registered values for EX, RegWrAddr_EX already resolved
//   StallCount                : saturating count of inserted bubbles
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Flush,
    input  logic [5:0]             OpCode_ID,
    input  logic [4:0]             RsAddr_ID,
    input  logic [4:0]             RtAddr_ID,
    input  logic [4:0]             RdAddr_ID,
    input  logic [1:0]             RegDst_ID,
    input  logic                   RegWrite_ID,
    input  logic                   MemWrite_ID,
    input  logic                   MemRead_ID,
    input  logic                   ALUSrc_ID,
    input  logic [31:0]            RsData_ID,
    input  logic [31:0]            RtData_ID,
    input  logic [31:0]            Imm_ID,
    input  logic [31:0]            PCPlus4_ID,
    output logic                   Stall_ID,
    output logic [5:0]             OpCode_EX,
    output logic [4:0]             RsAddr_EX,
    output logic [4:0]             RtAddr_EX,
    output logic [4:0]             RegWrAddr_EX,
    output logic                   RegWrite_EX,
    output logic                   MemWrite_EX,
    output logic                   MemRead_EX,
    output logic                   ALUSrc_EX,
    output logic                   Valid_EX,
    output logic [31:0]            RsData_EX,
    output logic [31:0]            RtData_EX,
    output logic [31:0]            Imm_EX,
    output logic [31:0]            PCPlus4_EX,
    output logic [STALL_CNT_W-1:0] StallCount
);

    ctrl_t ctrlEx;
    ctrl_t ctrlId;
    logic  hazard;
    logic  rsUsed;
    logic  rtUsed;
    logic  insertBubble;

    load_use_detect u_detect (
        .memReadEx   (ctrlEx.memRead),
        .validEx     (ctrlEx.valid),
        .regWrAddrEx (RegWrAddr_EX),
        .opCodeId    (OpCode_ID),
        .rsAddrId    (RsAddr_ID),
        .rtAddrId    (RtAddr_ID),
        .rsUsed      (rsUsed),
        .rtUsed      (rtUsed),
        .hazard      (hazard)
    );

    always_comb begin
        ctrlId.regWrite = RegWrite_ID;
        ctrlId.memWrite = MemWrite_ID;
        ctrlId.memRead  = MemRead_ID;
        ctrlId.aluSrc   = ALUSrc_ID;
        ctrlId.valid    = 1'b1;
        // The flushed instruction is discarded, so there is nothing to hold for
        Stall_ID        = hazard && !Flush;
        insertBubble    = Flush || hazard;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlEx       <= CTRL_BUBBLE;
            OpCode_EX    <= '0;
            RsAddr_EX    <= '0;
            RtAddr_EX    <= '0;
            RegWrAddr_EX <= '0;
            RsData_EX    <= '0;
            RtData_EX    <= '0;
            Imm_EX       <= '0;
            PCPlus4_EX   <= '0;
        end else if (insertBubble) begin
            // Data fields are don't-care in a bubble and simply hold
            ctrlEx       <= CTRL_BUBBLE;
            OpCode_EX    <= '0;
            RsAddr_EX    <= '0;
            RtAddr_EX    <= '0;
            RegWrAddr_EX <= '0;
        end else begin
            ctrlEx       <= ctrlId;
            OpCode_EX    <= OpCode_ID;
            RsAddr_EX    <= RsAddr_ID;
            RtAddr_EX    <= RtAddr_ID;
            RegWrAddr_EX <= resolveDest(RegDst_ID, RtAddr_ID, RdAddr_ID);
            RsData_EX    <= RsData_ID;
            RtData_EX    <= RtData_ID;
            Imm_EX       <= Imm_ID;
            PCPlus4_EX   <= PCPlus4_ID;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
        end else if (insertBubble && (StallCount != {STALL_CNT_W{1'b1}})) begin
            StallCount <= StallCount + 1'b1;
        end
    end

    always_comb begin
        RegWrite_EX = ctrlEx.regWrite;
        MemWrite_EX = ctrlEx.memWrite;
        MemRead_EX  = ctrlEx.memRead;
        ALUSrc_EX   = ctrlEx.aluSrc;
        Valid_EX    = ctrlEx.valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Flush = 1'b0;
    logic [5:0]  OpCode_ID = '0;
    logic [4:0]  RsAddr_ID = '0, RtAddr_ID = '0, RdAddr_ID = '0;
    logic [1:0]  RegDst_ID = '0;
    logic        RegWrite_ID = 1'b0, MemWrite_ID = 1'b0, MemRead_ID = 1'b0, ALUSrc_ID = 1'b0;
    logic [31:0] RsData_ID = '0, RtData_ID = '0, Imm_ID = '0, PCPlus4_ID = '0;
    logic        Stall_ID;
    logic [5:0]  OpCode_EX;
    logic [4:0]  RsAddr_EX, RtAddr_EX, RegWrAddr_EX;
    logic        RegWrite_EX, MemWrite_EX, MemRead_EX, ALUSrc_EX, Valid_EX;
    logic [31:0] RsData_EX, RtData_EX, Imm_EX, PCPlus4_EX;
    logic [3:0]  StallCount;

    int checks = 0;
    int passed = 0;

    id_ex_stage #(.STALL_CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .OpCode_ID(OpCode_ID), .RsAddr_ID(RsAddr_ID), .RtAddr_ID(RtAddr_ID),
        .RdAddr_ID(RdAddr_ID), .RegDst_ID(RegDst_ID), .RegWrite_ID(RegWrite_ID),
        .MemWrite_ID(MemWrite_ID), .MemRead_ID(MemRead_ID), .ALUSrc_ID(ALUSrc_ID),
        .RsData_ID(RsData_ID), .RtData_ID(RtData_ID), .Imm_ID(Imm_ID),
        .PCPlus4_ID(PCPlus4_ID), .Stall_ID(Stall_ID), .OpCode_EX(OpCode_EX),
        .RsAddr_EX(RsAddr_EX), .RtAddr_EX(RtAddr_EX), .RegWrAddr_EX(RegWrAddr_EX),
        .RegWrite_EX(RegWrite_EX), .MemWrite_EX(MemWrite_EX), .MemRead_EX(MemRead_EX),
        .ALUSrc_EX(ALUSrc_EX), .Valid_EX(Valid_EX), .RsData_EX(RsData_EX),
        .RtData_EX(RtData_EX), .Imm_EX(Imm_EX), .PCPlus4_EX(PCPlus4_EX),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [1:0] dst, input logic rw,
                         input logic mw, input logic mr, input logic as);
        OpCode_ID = op; RsAddr_ID = rs; RtAddr_ID = rt; RdAddr_ID = rd; RegDst_ID = dst;
        RegWrite_ID = rw; MemWrite_ID = mw; MemRead_ID = mr; ALUSrc_ID = as;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if ({Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX}); else passed++;
        checks++; if ({OpCode_EX, RegWrAddr_EX, RsAddr_EX} !== 16'h0) $display("FAIL reset_addr got %h want 0", {OpCode_EX, RegWrAddr_EX, RsAddr_EX}); else passed++;
        checks++; if (StallCount !== 4'd0 || Stall_ID !== 1'b0) $display("FAIL reset_count got %0d/%b want 0/0", StallCount, Stall_ID); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        // lw $8
        setId(6'h23, 5'd1, 5'd8, 5'd0, 2'd0, 1, 0, 1, 1);
        step();
        checks++; if (MemRead_EX !== 1'b1 || Valid_EX !== 1'b1 || RegWrAddr_EX !== 5'd8) $display("FAIL lu_lw_loaded got mr=%b v=%b dst=%0d want 1 1 8", MemRead_EX, Valid_EX, RegWrAddr_EX); else passed++;
        // add $9,$8,$10
        setId(6'h00, 5'd8, 5'd10, 5'd9, 2'd1, 1, 0, 0, 0);
        checks++; if (Stall_ID !== 1'b1) $display("FAIL lu_stall got %b want 1", Stall_ID); else passed++;
        step();
        checks++; if (Valid_EX !== 1'b0 || OpCode_EX !== 6'h0 || MemRead_EX !== 1'b0 || RegWrAddr_EX !== 5'd0) $display("FAIL lu_bubble got v=%b op=%h mr=%b dst=%0d want 0 0 0 0", Valid_EX, OpCode_EX, MemRead_EX, RegWrAddr_EX); else passed++;
        checks++; if (Stall_ID !== 1'b0 || StallCount !== 4'd1) $display("FAIL lu_after_bubble got stall=%b cnt=%0d want 0 1", Stall_ID, StallCount); else passed++;
        step();
        checks++; if (Valid_EX !== 1'b1 || RsAddr_EX !== 5'd8 || RegWrAddr_EX !== 5'd9 || StallCount !== 4'd1) $display("FAIL lu_consumer got v=%b rs=%0d dst=%0d cnt=%0d want 1 8 9 1", Valid_EX, RsAddr_EX, RegWrAddr_EX, StallCount); else passed++;
    endtask

    task automatic test_load_zero();
        setId(6'h23, 5'd2, 5'd0, 5'd0, 2'd0, 1, 0, 1, 1);
        step();
        setId(6'h00, 5'd0, 5'd0, 5'd4, 2'd1, 1, 0, 0, 0);
        checks++; if (Stall_ID !== 1'b0) $display("FAIL lz_stall got %b want 0", Stall_ID); else passed++;
        step();
        checks++; if (Valid_EX !== 1'b1 || RegWrAddr_EX !== 5'd4 || StallCount !== 4'd1) $display("FAIL lz_no_bubble got v=%b dst=%0d cnt=%0d want 1 4 1", Valid_EX, RegWrAddr_EX, StallCount); else passed++;
    endtask

    task automatic test_unused_rt();
        // lw $5
        setId(6'h23, 5'd3, 5'd5, 5'd0, 2'd0, 1, 0, 1, 1);
        step();
        // lui $5 reads no source register
        setId(6'h0f, 5'd0, 5'd5, 5'd0, 2'd0, 1, 0, 0, 1);
        checks++; if (Stall_ID !== 1'b0) $display("FAIL lui_stall got %b want 0", Stall_ID); else passed++;
        // sw $5 reads rt
        setId(6'h2b, 5'd1, 5'd5, 5'd0, 2'd0, 0, 1, 0, 1);
        checks++; if (Stall_ID !== 1'b1) $display("FAIL sw_stall got %b want 1", Stall_ID); else passed++;
        step();
        checks++; if (Valid_EX !== 1'b0 || StallCount !== 4'd2) $display("FAIL sw_bubble got v=%b cnt=%0d want 0 2", Valid_EX, StallCount); else passed++;
        step();
        checks++; if (Valid_EX !== 1'b1 || MemWrite_EX !== 1'b1 || RtAddr_EX !== 5'd5) $display("FAIL sw_loaded got v=%b mw=%b rt=%0d want 1 1 5", Valid_EX, MemWrite_EX, RtAddr_EX); else passed++;
    endtask

    task automatic test_flush_hazard();
        setId(6'h23, 5'd1, 5'd8, 5'd0, 2'd0, 1, 0, 1, 1);
        step();
        setId(6'h00, 5'd8, 5'd10, 5'd9, 2'd1, 1, 0, 0, 0);
        Flush = 1'b1;
        #1;
        checks++; if (Stall_ID !== 1'b0) $display("FAIL flush_stall got %b want 0", Stall_ID); else passed++;
        step();
        Flush = 1'b0;
        #1;
        checks++; if (Valid_EX !== 1'b0 || RegWrite_EX !== 1'b0 || StallCount !== 4'd3) $display("FAIL flush_bubble got v=%b rw=%b cnt=%0d want 0 0 3", Valid_EX, RegWrite_EX, StallCount); else passed++;
    endtask

    task automatic test_regdst();
        RsData_ID = 32'h1111_2222; RtData_ID = 32'h3333_4444; Imm_ID = 32'hffff_fff0; PCPlus4_ID = 32'h0040_0010;
        setId(6'h03, 5'd0, 5'd7, 5'd9, 2'd2, 1, 0, 0, 0);
        step();
        checks++; if (RegWrAddr_EX !== 5'd31 || OpCode_EX !== 6'h03 || RegWrite_EX !== 1'b1) $display("FAIL jal_dst got dst=%0d op=%h rw=%b want 31 03 1", RegWrAddr_EX, OpCode_EX, RegWrite_EX); else passed++;
        checks++; if (RsData_EX !== 32'h1111_2222 || RtData_EX !== 32'h3333_4444 || Imm_EX !== 32'hffff_fff0 || PCPlus4_EX !== 32'h0040_0010) $display("FAIL jal_data got %h %h %h %h want 11112222 33334444 fffffff0 00400010", RsData_EX, RtData_EX, Imm_EX, PCPlus4_EX); else passed++;
        setId(6'h00, 5'd1, 5'd6, 5'd12, 2'd3, 1, 0, 0, 0);
        step();
        checks++; if (RegWrAddr_EX !== 5'd6) $display("FAIL regdst3 got %0d want 6", RegWrAddr_EX); else passed++;
        setId(6'h00, 5'd1, 5'd6, 5'd12, 2'd1, 1, 0, 0, 0);
        step();
        checks++; if (RegWrAddr_EX !== 5'd12) $display("FAIL regdst1 got %0d want 12", RegWrAddr_EX); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        setId(6'h23, 5'd1, 5'd8, 5'd0, 2'd0, 1, 0, 1, 1);
        step();
        setId(6'h00, 5'd8, 5'd10, 5'd9, 2'd1, 1, 0, 0, 0);
        checks++; if (Stall_ID !== 1'b1) $display("FAIL rst_pre_stall got %b want 1", Stall_ID); else passed++;
        #1;
        reset = 1'b0;
        #1;
        checks++; if ({Valid_EX, MemRead_EX, RegWrite_EX, Stall_ID} !== 4'b0 || RegWrAddr_EX !== 5'd0 || StallCount !== 4'd0 || RsData_EX !== 32'h0) $display("FAIL rst_async got v=%b mr=%b rw=%b st=%b dst=%0d cnt=%0d rsd=%h want all 0", Valid_EX, MemRead_EX, RegWrite_EX, Stall_ID, RegWrAddr_EX, StallCount, RsData_EX); else passed++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (Stall_ID !== 1'b0) $display("FAIL rst_release_stall got %b want 0", Stall_ID); else passed++;
        step();
        checks++; if (Valid_EX !== 1'b1 || RsAddr_EX !== 5'd8 || StallCount !== 4'd0) $display("FAIL rst_release_load got v=%b rs=%0d cnt=%0d want 1 8 0", Valid_EX, RsAddr_EX, StallCount); else passed++;
    endtask

    task automatic test_saturation();
        Flush = 1'b1;
        for (int i = 0; i < 14; i++) step();
        checks++; if (StallCount !== 4'd14) $display("FAIL sat_14 got %0d want 14", StallCount); else passed++;
        step();
        checks++; if (StallCount !== 4'd15) $display("FAIL sat_15 got %0d want 15", StallCount); else passed++;
        step();
        step();
        checks++; if (StallCount !== 4'd15) $display("FAIL sat_hold got %0d want 15", StallCount); else passed++;
        Flush = 1'b0;
        #1;
        step();
        checks++; if (StallCount !== 4'd15 || Valid_EX !== 1'b1) $display("FAIL sat_resume got cnt=%0d v=%b want 15 1", StallCount, Valid_EX); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_zero();
        test_unused_rt();
        test_flush_hazard();
        test_regdst();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
